// File: rtl/chronologic_if.sv
// rtl/chronologic_if.sv - trigger/consequent inputs and check results for the chronologic checker
interface chronologic_if #(
  parameter int CNT_W = 16
);
  logic               a;
  logic               b;
  logic signed [31:0] delay;
  logic               pass;
  logic               fail;
  logic               busy;
  logic               clamped;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   fail_cnt;

  modport master (
    output a, b, delay,
    input  pass, fail, busy, clamped, pass_cnt, fail_cnt
  );

  modport slave (
    input  a, b, delay,
    output pass, fail, busy, clamped, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/chronologic.sv
// rtl/chronologic.sv - delayed implication checker: a with delay D expects b after D-1 cycles
module chronologic #(
  parameter int MAX_LAT = 15,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  chronologic_if.slave bus
);
  localparam int LW = $clog2(MAX_LAT + 2);
  localparam int signed MAX_S = MAX_LAT;

  logic [MAX_LAT:0] pend_q;
  logic [MAX_LAT:0] pend_nxt;
  logic [MAX_LAT:0] sched;
  logic [LW-1:0]    lat;
  logic             clamp;
  logic             due;
  logic             pass_q;
  logic             fail_q;
  logic             clamped_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;

  always_comb begin
    lat   = '0;
    clamp = 1'b0;
    if (bus.a && bus.delay > 32'sd1) begin
      if (bus.delay - 32'sd1 > MAX_S) begin
        clamp = 1'b1;
        lat   = LW'(MAX_LAT);
      end else begin
        lat = LW'(bus.delay - 32'sd1);
      end
    end
  end

  // A latency of L lands in slot L-1 after this cycle's shift.
  always_comb begin
    sched = '0;
    for (int k = 0; k <= MAX_LAT; k++) begin
      sched[k] = bus.a && (lat == LW'(k + 1));
    end
  end

  assign due      = pend_q[0] | (bus.a && lat == '0);
  assign pend_nxt = {1'b0, pend_q[MAX_LAT:1]} | sched;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      clamped_q  <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pend_q    <= pend_nxt;
      pass_q    <= due & bus.b;
      fail_q    <= due & ~bus.b;
      clamped_q <= clamp;
      if (due && bus.b && !(&pass_cnt_q)) begin
        pass_cnt_q <= pass_cnt_q + CNT_W'(1);
      end
      if (due && !bus.b && !(&fail_cnt_q)) begin
        fail_cnt_q <= fail_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.clamped  = clamped_q;
  assign bus.busy     = |pend_q;
  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
endmodule

// File: tb/tb_chronologic.sv
// tb/tb_chronologic.sv - scoreboard bench for chronologic with directed trigger vectors
module tb_chronologic;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = 7;

  typedef struct {
    int   cyc;
    logic is_pass;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_pass = 0;
  int   exp_fail = 0;
  ev_t  ev_q[$];
  int   clamp_q[$];

  chronologic_if #(.CNT_W(CNT_W)) bus ();

  chronologic #(.MAX_LAT(15), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic is_pass);
    ev_t e;
    e.cyc = c;
    e.is_pass = is_pass;
    ev_q.push_back(e);
    if (is_pass) begin
      if (exp_pass < CNT_MAX) exp_pass++;
    end else begin
      if (exp_fail < CNT_MAX) exp_fail++;
    end
  endtask

  task automatic drive(input logic av, input logic bv, input int d);
    bus.a = av;
    bus.b = bv;
    bus.delay = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
  endtask

  task automatic chk_cnts(input string nm);
    chk({nm, "_pass_cnt"}, int'(bus.pass_cnt), exp_pass);
    chk({nm, "_fail_cnt"}, int'(bus.fail_cnt), exp_fail);
  endtask

  // Monitor: every pass/fail/clamped pulse must match the head of its queue.
  always @(negedge clk) begin
    while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_result: got none expected %s at cycle %0d",
               ev_q[0].is_pass ? "pass" : "fail", ev_q[0].cyc);
      void'(ev_q.pop_front());
    end
    while (clamp_q.size() > 0 && clamp_q[0] < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_clamp: got none expected clamped at cycle %0d", clamp_q[0]);
      void'(clamp_q.pop_front());
    end
    if (bus.pass && bus.fail) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pass_and_fail: got both high expected exclusive at cycle %0d", cyc);
    end
    if (bus.pass || bus.fail) begin
      n_cmp++;
      if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
        n_bad++;
        $display("FAIL unexpected_result: got pass=%0b fail=%0b expected none at cycle %0d",
                 bus.pass, bus.fail, cyc);
      end else begin
        if (ev_q[0].is_pass != bus.pass) begin
          n_bad++;
          $display("FAIL result_kind: got pass=%0b expected pass=%0b at cycle %0d",
                   bus.pass, ev_q[0].is_pass, cyc);
        end
        void'(ev_q.pop_front());
      end
    end
    if (bus.clamped) begin
      n_cmp++;
      if (clamp_q.size() == 0 || clamp_q[0] != cyc) begin
        n_bad++;
        $display("FAIL unexpected_clamp: got clamped=1 expected 0 at cycle %0d", cyc);
      end else begin
        void'(clamp_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    bus.a = 1'b0;
    bus.b = 1'b0;
    bus.delay = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_pass", int'(bus.pass), 0);
    chk_cnts("reset");
    rst = 1'b0;

    // D=2, b low at the check cycle
    t = cyc;
    push_ev(t + 2, 1'b0);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 0);
    idle(3);
    chk_cnts("d2_fail");

    // Back-to-back D=2 triggers
    t = cyc;
    push_ev(t + 2, 1'b1);
    push_ev(t + 3, 1'b1);
    drive(1'b1, 1'b0, 2);
    drive(1'b1, 1'b1, 2);
    drive(1'b0, 1'b1, 0);
    idle(3);
    chk_cnts("overlap");

    // Same-cycle checks for D<=1
    t = cyc;
    push_ev(t + 1, 1'b1);
    drive(1'b1, 1'b1, 0);
    chk("d0_busy", int'(bus.busy), 0);
    idle(2);
    t = cyc;
    push_ev(t + 1, 1'b1);
    drive(1'b1, 1'b1, -5);
    chk("dneg_busy", int'(bus.busy), 0);
    idle(2);
    t = cyc;
    push_ev(t + 1, 1'b0);
    drive(1'b1, 1'b0, 1);
    idle(2);
    chk_cnts("same_cycle");

    // D=40 clamps to 15: check at t+15, result at t+16
    t = cyc;
    clamp_q.push_back(t + 1);
    push_ev(t + 16, 1'b1);
    drive(1'b1, 1'b0, 40);
    idle(14);
    chk("clamp_busy", int'(bus.busy), 1);
    drive(1'b0, 1'b1, 0);
    idle(3);
    chk("clamp_idle_busy", int'(bus.busy), 0);

    // D=16 is the largest unclamped delay
    t = cyc;
    push_ev(t + 16, 1'b0);
    drive(1'b1, 1'b0, 16);
    idle(18);

    // D=17 is the smallest clamped delay
    t = cyc;
    clamp_q.push_back(t + 1);
    push_ev(t + 16, 1'b1);
    drive(1'b1, 1'b0, 17);
    idle(14);
    drive(1'b0, 1'b1, 0);
    idle(3);
    chk_cnts("clamp");

    // D=4 and later D=2 land on the same check cycle: one merged result
    t = cyc;
    push_ev(t + 4, 1'b1);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b1, 0);
    idle(3);
    chk_cnts("merge");

    // Reset drops a pending D=5 check and a trigger in the reset cycle
    drive(1'b1, 1'b1, 5);
    drive(1'b0, 1'b1, 0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1);
    rst = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    chk("rst_busy", int'(bus.busy), 0);
    chk_cnts("rst");
    bus.b = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 0);
    chk_cnts("rst_quiet");

    // Pass counter saturates at all-ones
    for (int i = 0; i < 9; i++) begin
      push_ev(cyc + 1, 1'b1);
      drive(1'b1, 1'b1, 1);
    end
    push_ev(cyc + 1, 1'b0);
    drive(1'b1, 1'b0, 1);
    idle(3);
    chk_cnts("saturate");

    while (ev_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_result: got none expected result at cycle %0d", ev_q[0].cyc);
      void'(ev_q.pop_front());
    end
    while (clamp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_clamp: got none expected clamped at cycle %0d", clamp_q[0]);
      void'(clamp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
